// File: rtl/mult_arbiter_seq_if.sv
// mult_arbiter_seq_if
//   Bundles the request/grant/result signals shared by the two requesters
//   and the sequential multiplier.
//   master : requester side (drives req and operands, observes the results)
//   slave  : multiplier side
// Ports (all signals):
//   req[1:0]          level request, bit i belongs to requester i
//   a0,b0 / a1,b1     multiplicand / multiplier of requester 0 / 1
//   gnt[1:0]          one-cycle pulse: operands of requester i captured
//   done[1:0]         one-cycle pulse: p holds requester i's product
//   p[2*WIDTH-1:0]    product register
//   busy              multiply in progress
// Handshake: req[i] is only looked at while the multiplier is idle or
//   finishing; a requester holds its operands stable until it sees gnt[i]
//   and drops req[i] in that gnt cycle. A req still high at the next
//   sampling edge is a new request.
interface mult_arbiter_seq_if #(
  parameter int WIDTH = 4
) ();
  logic [1:0]         req;
  logic [WIDTH-1:0]   a0;
  logic [WIDTH-1:0]   b0;
  logic [WIDTH-1:0]   a1;
  logic [WIDTH-1:0]   b1;
  logic [1:0]         gnt;
  logic [1:0]         done;
  logic [2*WIDTH-1:0] p;
  logic               busy;

  modport master (
    output req, a0, b0, a1, b1,
    input  gnt, done, p, busy
  );

  modport slave (
    input  req, a0, b0, a1, b1,
    output gnt, done, p, busy
  );
endinterface

// File: rtl/mult_arbiter_seq.sv
// mult_arbiter_seq
//   Shift-and-add unsigned WIDTH x WIDTH multiplier shared by two requesters
//   through a round-robin arbiter. One product takes WIDTH CALC cycles plus
//   one FIN cycle, during which a new request may already be granted.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        mult_arbiter_seq_if.slave (req/operands in, gnt/done/p/busy out)
//   dbg_state  current FSM state (IDLE=0, CALC=1, FIN=2)
// WIDTH must be at least 2.
module mult_arbiter_seq #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mult_arbiter_seq_if.slave     bus,
  output logic [1:0]            dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;

  // acc = {hi, lo}; the adder carry only exists inside sum and is shifted
  // straight into hi, so it never needs its own flop.
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mcand;
  logic [CW-1:0]        cnt;
  logic                 owner;
  logic                 last;     // requester granted most recently
  logic [1:0]           gnt_r;
  logic [1:0]           done_r;
  logic [2*WIDTH-1:0]   p_r;
  logic                 busy_r;

  logic                 win;
  logic                 grant_en;
  logic                 last_iter;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_shift;

  // Arbitration: a lone requester wins; on a tie the one not granted last.
  always_comb begin
    win = 1'b0;
    if (bus.req == 2'b11) begin
      win = ~last;
    end else begin
      win = bus.req[1];
    end
  end

  // One shift-and-add iteration on the current accumulator.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) begin
      sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end
    acc_shift = {sum, acc[WIDTH-1:1]};
  end

  // Next-state logic. FIN samples requests exactly like IDLE.
  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    last_iter  = 1'b0;
    case (state)
      IDLE, FIN: begin
        grant_en   = |bus.req;
        state_next = grant_en ? CALC : IDLE;
      end
      CALC: begin
        last_iter  = (cnt == CW'(WIDTH - 1));
        state_next = last_iter ? FIN : CALC;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
      owner  <= 1'b0;
      last   <= 1'b1;     // requester 0 wins the first tie
      gnt_r  <= 2'b00;
      done_r <= 2'b00;
      p_r    <= '0;
      busy_r <= 1'b0;
    end else begin
      gnt_r  <= 2'b00;
      done_r <= 2'b00;
      busy_r <= (state_next != IDLE);
      if (grant_en) begin
        mcand <= win ? bus.a1 : bus.a0;
        acc   <= {{WIDTH{1'b0}}, (win ? bus.b1 : bus.b0)};
        cnt   <= '0;
        owner <= win;
        last  <= win;
        gnt_r <= win ? 2'b10 : 2'b01;
      end else if (state == CALC) begin
        acc <= acc_shift;
        cnt <= cnt + CW'(1);
        if (last_iter) begin
          p_r    <= acc_shift;
          done_r <= owner ? 2'b10 : 2'b01;
        end
      end
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.done  = done_r;
  assign bus.p     = p_r;
  assign bus.busy  = busy_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_mult_arbiter_seq.sv
// tb_mult_arbiter_seq
//   Scenario tasks for mult_arbiter_seq, compared against a behavioural
//   model: products from plain multiplication, grant order from the
//   round-robin rule, latencies from the handshake timing.
module tb_mult_arbiter_seq;
  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  mult_arbiter_seq_if #(.WIDTH(W)) bus ();

  mult_arbiter_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [1:0]     own_q[$];
  logic           model_last;   // requester most recently granted

  // Round-robin rule: lone requester wins; on a tie, not the last winner.
  function automatic logic model_win(input logic [1:0] pend, input logic lst);
    if (pend == 2'b01) return 1'b0;
    if (pend == 2'b10) return 1'b1;
    return (lst == 1'b0) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int prod;
    prod = int'(a) * int'(b);
    return (2*W)'(prod);
  endfunction

  function automatic logic [1:0] onehot(input logic who);
    return who ? 2'b10 : 2'b01;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
  endtask

  task automatic set_ops(input int who, input logic [W-1:0] a, input logic [W-1:0] b);
    if (who == 0) begin
      bus.a0 = a; bus.b0 = b;
    end else begin
      bus.a1 = a; bus.b1 = b;
    end
  endtask

  // One complete single-requester transaction; returns what was observed.
  task automatic issue(input int who, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [1:0] g, output int glat,
                       output logic [1:0] d, output int dlat,
                       output logic [2*W-1:0] pv, output logic busy_done);
    @(negedge clk);
    set_ops(who, a, b);
    bus.req[who] = 1'b1;
    g = 2'b00; glat = 0;
    while (g == 2'b00 && glat < 20) begin
      @(negedge clk); glat++; g = bus.gnt;
    end
    bus.req[who] = 1'b0;
    // operand changes after the grant must not matter
    set_ops(who, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    d = 2'b00; dlat = 0; pv = '0; busy_done = 1'b0;
    while (d == 2'b00 && dlat < 20) begin
      @(negedge clk); dlat++; d = bus.done; pv = bus.p; busy_done = bus.busy;
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 2'b00;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    #1;
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", bus.gnt); end
    checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", bus.done); end
    checks++; if (bus.p !== 8'h00) begin errors++; $display("FAIL reset_p got %h want 00", bus.p); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
  endtask

  task automatic test_single(input int who, input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
    logic [1:0] g, d; int glat, dlat; logic [2*W-1:0] pv, e; logic bd;
    exp_q.push_back(model_mul(a, b));
    issue(who, a, b, g, glat, d, dlat, pv, bd);
    model_last = who[0];
    e = exp_q.pop_front();
    checks++; if (g !== onehot(who[0]) || glat != 1) begin errors++;
      $display("FAIL %s_gnt got %b after %0d want %b after 1", nm, g, glat, onehot(who[0])); end
    checks++; if (d !== onehot(who[0]) || dlat != W) begin errors++;
      $display("FAIL %s_done got %b after %0d want %b after %0d", nm, d, dlat, onehot(who[0]), W); end
    checks++; if (pv !== e) begin errors++; $display("FAIL %s_p got %h want %h", nm, pv, e); end
    checks++; if (bd !== 1'b1) begin errors++; $display("FAIL %s_busy_fin got %b want 1", nm, bd); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.p !== e) begin errors++;
      $display("FAIL %s_idle busy %b p %h want busy 0 p %h", nm, bus.busy, bus.p, e); end
  endtask

  task automatic test_zero();
    test_single(1, 4'h0, 4'h9, "zero_a");
    test_single(1, 4'h7, 4'h0, "zero_b");
  endtask

  task automatic test_round_robin();
    int cyc, ngr, ndone, last_g;
    logic [1:0] raise, pend;
    logic exp_w;
    logic [1:0] eo; logic [2*W-1:0] e;
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = 2'b11;
    set_ops(0, 4'd3, 4'd5);
    set_ops(1, 4'd6, 4'd7);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    cyc = 0; ngr = 0; ndone = 0; last_g = 0; raise = 2'b00;
    while (ndone < 3 && cyc < 60) begin
      pend = bus.req;              // what the last rising edge sampled
      @(negedge clk); cyc++;
      bus.req = bus.req | raise;
      raise = 2'b00;
      if (bus.gnt !== 2'b00) begin
        exp_w = model_win(pend, model_last);
        model_last = exp_w;
        checks++; if (bus.gnt !== onehot(exp_w)) begin errors++;
          $display("FAIL rr_grant%0d got %b want %b", ngr, bus.gnt, onehot(exp_w)); end
        if (ngr > 0) begin
          checks++; if (cyc - last_g != W + 1) begin errors++;
            $display("FAIL rr_gap%0d got %0d want %0d", ngr, cyc - last_g, W + 1); end
        end
        exp_q.push_back(exp_w ? model_mul(4'd6, 4'd7) : model_mul(4'd3, 4'd5));
        own_q.push_back(onehot(exp_w));
        last_g = cyc;
        ngr++;
        bus.req[exp_w] = 1'b0;
        if (ngr < 3) raise[exp_w] = 1'b1;
        else bus.req = 2'b00;
      end
      if (bus.done !== 2'b00 && exp_q.size() > 0) begin
        e = exp_q.pop_front(); eo = own_q.pop_front();
        checks++; if (bus.done !== eo || bus.p !== e) begin errors++;
          $display("FAIL rr_done%0d got %b/%h want %b/%h", ndone, bus.done, bus.p, eo, e); end
        ndone++;
      end
    end
    checks++; if (ngr != 3 || ndone != 3) begin errors++;
      $display("FAIL rr_count grants %0d dones %0d want 3 3", ngr, ndone); end
    exp_q.delete(); own_q.delete();
    @(negedge clk);
  endtask

  task automatic test_preempt();
    logic [W-1:0] a0, b0, a1, b1;
    int n, gap; logic w1, w2; logic seen_d;
    a0 = W'($urandom_range(0, 15)); b0 = W'($urandom_range(0, 15));
    a1 = W'($urandom_range(0, 15)); b1 = W'($urandom_range(0, 15));
    @(negedge clk);
    set_ops(0, a0, b0); set_ops(1, a1, b1);
    bus.req = 2'b01;
    w1 = model_win(2'b01, model_last);
    n = 0;
    while (bus.gnt === 2'b00 && n < 20) begin @(negedge clk); n++; end
    model_last = w1;
    checks++; if (bus.gnt !== onehot(w1)) begin errors++;
      $display("FAIL preempt_first got %b want %b", bus.gnt, onehot(w1)); end
    @(negedge clk);
    bus.req = 2'b11;               // requester 1 arrives during CALC
    w2 = model_win(2'b11, model_last);
    gap = 1; seen_d = 1'b0;
    while (bus.gnt === 2'b00 && gap < 20) begin
      @(negedge clk); gap++;
      if (bus.done !== 2'b00) begin
        seen_d = 1'b1;
        checks++; if (bus.done !== 2'b01 || bus.p !== model_mul(a0, b0)) begin errors++;
          $display("FAIL preempt_done0 got %b/%h want 01/%h", bus.done, bus.p, model_mul(a0, b0)); end
      end
    end
    model_last = w2;
    checks++; if (bus.gnt !== onehot(w2) || gap != W + 1 || !seen_d) begin errors++;
      $display("FAIL preempt_second got %b gap %0d done_seen %b want %b gap %0d", bus.gnt, gap, seen_d, onehot(w2), W + 1); end
    bus.req = 2'b00;
    n = 0;
    while (bus.done === 2'b00 && n < 20) begin @(negedge clk); n++; end
    checks++; if (bus.done !== 2'b10 || bus.p !== model_mul(a1, b1) || n != W) begin errors++;
      $display("FAIL preempt_done1 got %b/%h after %0d want 10/%h after %0d", bus.done, bus.p, n, model_mul(a1, b1), W); end
    @(negedge clk);
  endtask

  task automatic test_pulse_busy();
    logic [W-1:0] a1, b1; logic [2*W-1:0] e; int n; int extra;
    a1 = W'($urandom_range(1, 15)); b1 = W'($urandom_range(1, 15));
    e = model_mul(a1, b1);
    @(negedge clk);
    set_ops(1, a1, b1);
    bus.req = 2'b10;
    n = 0;
    while (bus.gnt === 2'b00 && n < 20) begin @(negedge clk); n++; end
    model_last = 1'b1;
    bus.req = 2'b00;
    @(negedge clk);
    set_ops(0, 4'd5, 4'd5);
    bus.req = 2'b01;               // short pulse inside CALC
    @(negedge clk);
    bus.req = 2'b00;
    n = 0;
    while (bus.done === 2'b00 && n < 20) begin @(negedge clk); n++; end
    checks++; if (bus.done !== 2'b10 || bus.p !== e) begin errors++;
      $display("FAIL pulse_done got %b/%h want 10/%h", bus.done, bus.p, e); end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.gnt !== 2'b00 || bus.done !== 2'b00 || bus.p !== e) extra++;
    end
    checks++; if (extra != 0) begin errors++;
      $display("FAIL pulse_quiet got %0d bad cycles want 0 (p %h want %h)", extra, bus.p, e); end
  endtask

  task automatic test_reset_mid();
    int n, stray;
    @(negedge clk);
    set_ops(0, 4'd9, 4'd13);
    bus.req = 2'b01;
    n = 0;
    while (bus.gnt === 2'b00 && n < 20) begin @(negedge clk); n++; end
    bus.req = 2'b00;
    repeat (2) @(negedge clk);     // two iterations done
    rst_n = 1'b0;
    #1;
    checks++; if (bus.gnt !== 2'b00 || bus.done !== 2'b00 || bus.p !== 8'h00 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL midreset_async gnt %b done %b p %h busy %b want all 0", bus.gnt, bus.done, bus.p, bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done !== 2'b00 || bus.gnt !== 2'b00) stray++;
    end
    checks++; if (stray != 0) begin errors++;
      $display("FAIL midreset_nodone got %0d stray pulses want 0", stray); end
    test_single(0, 4'd9, 4'd13, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      test_single(int'($urandom_range(0, 1)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), "rand");
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single(0, 4'hF, 4'hF, "max");
    test_zero();
    test_round_robin();
    test_preempt();
    test_pulse_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mult_arbiter_seq.md
Name: mult_arbiter_seq

Overview:
- Sequential shift-and-add multiplier that computes a WIDTH x WIDTH unsigned product over WIDTH clock cycles, using one WIDTH-bit adder.
- Two requesters share it through a round-robin arbiter and a GNT/DONE handshake.
- It is the time-multiplexed alternative to the combinational array multiplier, for datapaths where area matters more than latency.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- REQ  input  2  REQ[i] high = requester i asks for a multiply; level-sensitive.
- A0  input  WIDTH  multiplicand, requester 0.
- B0  input  WIDTH  multiplier, requester 0.
- A1  input  WIDTH  multiplicand, requester 1.
- B1  input  WIDTH  multiplier, requester 1.
- GNT  output  2  one-hot, one-cycle pulse: operands of requester i were captured.
- DONE  output  2  one-hot, one-cycle pulse: P holds requester i's product.
- P  output  2*WIDTH  product register.
- BUSY  output  1  high while a multiply is in progress (CALC or FIN).

Behaviour:
- Reset: async, active-low; RST_N low forces the outputs and state below immediately.
  - State IDLE; GNT=0, DONE=0, P=0, BUSY=0.
  - Accumulator and count cleared.
  - Round-robin pointer set so requester 0 wins the first tie.
- FSM states: IDLE, CALC, FIN.
- IDLE: on an edge with REQ!=0:
  - Arbitrate and latch the winner's A/B.
  - Accumulator = {carry=0, hi=0, lo=B}; count=0.
  - GNT[winner]=1 for the following cycle; BUSY=1; go to CALC.
  - With REQ=0, stay in IDLE.
- Arbitration:
  - A single requester always wins.
  - If both request, the one not granted most recently wins; the pointer updates on every grant.
- CALC, one iteration per edge:
  - If lo[0]=1: {carry,hi} = hi + A (WIDTH+1-bit sum); else {carry,hi} = {0,hi}.
  - Then shift {carry,hi,lo} right by 1; count++.
  - After the WIDTH-th iteration (count==WIDTH-1 at the edge): P = {hi,lo} after that shift; DONE[owner]=1 for the next cycle; go to FIN.
- Arithmetic: the result is exact and unsigned; 2*WIDTH bits never overflow. Max 4-bit case: 15*15 = 225 = 8'hE1.
- FIN (DONE pulse cycle; BUSY stays 1):
  - Behaves as IDLE for arbitration.
  - REQ!=0 on this edge grants immediately: next state CALC with GNT pulse, else IDLE with BUSY=0.
  - Back-to-back throughput is one product per WIDTH+1 cycles.
- Timing, with grant edge E0:
  - GNT high in cycle E0..E1.
  - DONE high in cycle E_WIDTH..E_WIDTH+1.
  - P updates at edge E_WIDTH and holds until the next DONE.
- Handshake rules:
  - REQ is sampled only in IDLE and FIN.
  - Operands must be stable on the sampling edge; changes after GNT have no effect.
  - The requester must drop REQ in the GNT cycle. REQ still high at the next IDLE/FIN sampling edge is a new request.
  - REQ dropped before GNT withdraws the request; no GNT or DONE is issued for it.
  - REQ asserted during CALC waits. The other requester therefore gets the next grant if both are pending, per round-robin.
- Outputs:
  - GNT and DONE are registered and never both nonzero in the same cycle for different owners.
  - DONE goes only to the owner captured at grant.
- Reset mid-operation: the calculation is aborted, no DONE is issued, and P is cleared to 0.
- Zero operands need no special case: still WIDTH cycles, P=0.

Test Plan:
- Reset then REQ=2'b01, A0=4'hF, B0=4'hF -> GNT=01 one cycle after the sampling edge; DONE=01 and P=8'hE1 exactly 4 edges after grant; BUSY falls one cycle later.
- REQ=2'b10, A1=4'h0, B1=4'h9 and A1=4'h7, B1=4'h0 -> P=8'h00 each time, same 4-cycle latency, DONE=10.
- REQ=2'b11 held from reset (A0=3,B0=5; A1=6,B1=7); each requester drops REQ on its own GNT, then re-raises it at the next sampling edge, over three consecutive grants -> grants 01, 10, 01; results 8'h0F, 8'h2A, 8'h0F; grants 5 cycles apart (back-to-back via FIN).
- REQ0 held continuously, REQ1 asserted during requester 0's CALC -> next grant is 10, not 01.
- RST_N pulsed low at CALC iteration 2 of 9*13 -> outputs 0 asynchronously, no DONE; after release, fresh request 9*13 -> P=8'h75.
- REQ0 pulsed for one cycle while BUSY, gone before FIN -> no GNT or DONE for requester 0; P unchanged.
